// File: rtl/screen_writer_pkg.sv
// Shared constants, ASCII codes and enums for the screen writer.
// Imported by the interface, cursor controller and top level.
package screen_pkg;

    localparam int COLS         = 128;
    localparam int ROWS         = 80;
    localparam int SCREEN_CELLS = 10240;
    localparam int ADDR_W       = 15;

    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] FF  = 8'h0C;
    localparam logic [7:0] NUL = 8'h00;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADV,
        OP_LF,
        OP_CR,
        OP_BS,
        OP_HOME
    } cur_op_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/screen_writer_if.sv
// Character input handshake plus screen RAM write port bundle.
// master drives characters, slave is the screen writer.
interface screen_writer_if;

    logic                          char_valid;
    logic [7:0]                    char_in;
    logic                          char_ready;
    logic                          we;
    logic [screen_pkg::ADDR_W-1:0] waddr;
    logic [7:0]                    wdata;
    logic [screen_pkg::ADDR_W-1:0] cursor_addr;
    logic                          busy;

    modport master (
        output char_valid,
        output char_in,
        input  char_ready,
        input  we,
        input  waddr,
        input  wdata,
        input  cursor_addr,
        input  busy
    );

    modport slave (
        input  char_valid,
        input  char_in,
        output char_ready,
        output we,
        output waddr,
        output wdata,
        output cursor_addr,
        output busy
    );

endinterface

// File: rtl/screen_writer_cursor_ctrl.sv
// Row/column cursor with wrap-around movement operations.
// Publishes the registered linear address and the post-operation address.
module cursor_ctrl #(
    parameter int COLS = screen_pkg::COLS,
    parameter int ROWS = screen_pkg::ROWS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  screen_pkg::cur_op_e           op,
    output logic [screen_pkg::ADDR_W-1:0] addr,
    output logic [screen_pkg::ADDR_W-1:0] next_addr,
    output logic                          at_home
);
    import screen_pkg::*;

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [RW-1:0] row_inc;

    assign row_inc = (row == ROW_MAX) ? '0 : row + 1'b1;
    assign at_home = (row == '0) && (col == '0);

    // Apply the requested cursor operation to get the next position.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        case (op)
            OP_ADV: begin
                if (col == COL_MAX) begin
                    col_nxt = '0;
                    row_nxt = row_inc;
                end else begin
                    col_nxt = col + 1'b1;
                end
            end
            OP_LF: begin
                col_nxt = '0;
                row_nxt = row_inc;
            end
            OP_CR: begin
                col_nxt = '0;
            end
            OP_BS: begin
                if (col != '0) begin
                    col_nxt = col - 1'b1;
                end else if (row != '0) begin
                    col_nxt = COL_MAX;
                    row_nxt = row - 1'b1;
                end
            end
            OP_HOME: begin
                col_nxt = '0;
                row_nxt = '0;
            end
            default: ;
        endcase
    end

    assign next_addr = ADDR_W'(row_nxt) * ADDR_W'(COLS) + ADDR_W'(col_nxt);

    // Cursor registers; the linear address is kept registered alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            col  <= col_nxt;
            row  <= row_nxt;
            addr <= next_addr;
        end
    end

endmodule

// File: rtl/screen_writer.sv
// Text-mode screen writer: turns a character stream into screen RAM
// writes, handling control codes and a full-screen clear sweep.
module screen_writer #(
    parameter int COLS = screen_pkg::COLS,
    parameter int ROWS = screen_pkg::ROWS
) (
    input logic            clk,
    input logic            rst_n,
    screen_writer_if.slave bus
);
    import screen_pkg::*;

    localparam int              CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    state_e            state, state_nxt;
    cur_op_e           op;
    logic [ADDR_W-1:0] cur_addr, next_addr;
    logic              at_home;
    logic [ADDR_W-1:0] clr_cnt, clr_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [7:0]        wdata_nxt;
    logic              fire;

    cursor_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_cursor (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .addr     (cur_addr),
        .next_addr(next_addr),
        .at_home  (at_home)
    );

    assign bus.char_ready  = (state == IDLE);
    assign bus.busy        = (state == CLEAR);
    assign bus.cursor_addr = cur_addr;
    assign fire            = bus.char_valid && (state == IDLE);

    // Next-state, cursor operation and write-port decisions.
    always_comb begin
        state_nxt = state;
        op        = OP_NONE;
        clr_nxt   = clr_cnt;
        we_nxt    = 1'b0;
        waddr_nxt = bus.waddr;
        wdata_nxt = bus.wdata;
        case (state)
            IDLE: begin
                if (fire) begin
                    unique case (1'b1)
                        is_printable(bus.char_in): begin
                            op        = OP_ADV;
                            we_nxt    = 1'b1;
                            waddr_nxt = cur_addr;
                            wdata_nxt = bus.char_in;
                        end
                        bus.char_in == LF: op = OP_LF;
                        bus.char_in == CR: op = OP_CR;
                        bus.char_in == BS: begin
                            if (!at_home) begin
                                op        = OP_BS;
                                we_nxt    = 1'b1;
                                waddr_nxt = next_addr;
                                wdata_nxt = NUL;
                            end
                        end
                        bus.char_in == FF: begin
                            state_nxt = CLEAR;
                            clr_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                we_nxt    = 1'b1;
                waddr_nxt = clr_cnt;
                wdata_nxt = NUL;
                if (clr_cnt == LAST) begin
                    state_nxt = IDLE;
                    op        = OP_HOME;
                end else begin
                    clr_nxt = clr_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, sweep counter and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            bus.we    <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_nxt;
            bus.we    <= we_nxt;
            bus.waddr <= waddr_nxt;
            bus.wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_screen_writer.sv
// Directed bench for screen_writer: writes, wraps, control codes,
// clear sweep and reset during a sweep.
module tb_screen_writer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    screen_writer_if bus ();

    screen_writer #(
        .COLS(128),
        .ROWS(80)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer c for one edge, then sample 1ns after the edge.
    task automatic send(input logic [7:0] c);
        bus.char_valid = 1'b1;
        bus.char_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.char_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [14:0] a,
                          input logic [7:0] d, input logic [14:0] cur);
        chk({tag, "_we"}, {31'd0, bus.we}, 32'd1);
        chk({tag, "_waddr"}, {17'd0, bus.waddr}, {17'd0, a});
        chk({tag, "_wdata"}, {24'd0, bus.wdata}, {24'd0, d});
        chk({tag, "_cur"}, {17'd0, bus.cursor_addr}, {17'd0, cur});
    endtask

    task automatic chk_nowr(input string tag, input logic [14:0] cur);
        chk({tag, "_we"}, {31'd0, bus.we}, 32'd0);
        chk({tag, "_cur"}, {17'd0, bus.cursor_addr}, {17'd0, cur});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, {31'd0, bus.we}, 32'd0);
        chk({tag, "_waddr"}, {17'd0, bus.waddr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, bus.wdata}, 32'd0);
        chk({tag, "_cur"}, {17'd0, bus.cursor_addr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.char_ready}, 32'd1);
    endtask

    initial begin
        int bad;
        int busy_bad;
        int stray;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'h41);
        chk_wr("wr_A", 15'd0, 8'h41, 15'd1);
        chk("ready_A", {31'd0, bus.char_ready}, 32'd1);
        send(8'h42);
        chk_wr("wr_B", 15'd1, 8'h42, 15'd2);
        chk("ready_B", {31'd0, bus.char_ready}, 32'd1);

        for (int i = 0; i < 125; i++) send(8'h78);
        chk("cur_0_127", {17'd0, bus.cursor_addr}, 32'd127);
        send(8'h5A);
        chk_wr("wr_Z", 15'd127, 8'h5A, 15'd128);

        for (int i = 0; i < 78; i++) send(8'h0A);
        chk_nowr("lf_to_79", 15'd10112);
        for (int i = 0; i < 127; i++) send(8'h79);
        chk("cur_79_127", {17'd0, bus.cursor_addr}, 32'd10239);
        send(8'h51);
        chk_wr("wr_Q_wrap", 15'd10239, 8'h51, 15'd0);

        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h7A);
        chk_wr("wr_3_4", 15'd388, 8'h7A, 15'd389);
        send(8'h0A);
        chk_nowr("lf_3_5", 15'd512);
        send(8'h08);
        chk_wr("bs_4_0", 15'd511, 8'h00, 15'd511);
        idle();
        chk_nowr("idle", 15'd511);
        chk("waddr_hold", {17'd0, bus.waddr}, 32'd511);

        send(8'h41);
        chk_wr("wr_A2", 15'd511, 8'h41, 15'd512);
        send(8'h0D);
        chk_nowr("cr", 15'd512);
        send(8'h7F);
        chk_nowr("del_ignored", 15'd512);
        send(8'h01);
        chk_nowr("soh_ignored", 15'd512);

        send(8'h0C);
        chk("ff_busy", {31'd0, bus.busy}, 32'd1);
        chk("ff_ready", {31'd0, bus.char_ready}, 32'd0);
        chk("ff_we", {31'd0, bus.we}, 32'd0);
        bus.char_in = 8'h4B;
        bad      = 0;
        busy_bad = 0;
        for (int i = 0; i < 10240; i++) begin
            @(posedge clk);
            #1;
            if (bus.we !== 1'b1 || bus.waddr !== 15'(i) ||
                bus.wdata !== 8'h00)
                bad++;
            if (i < 10239 && (bus.busy !== 1'b1 || bus.char_ready !== 1'b0))
                busy_bad++;
        end
        chk("sweep_writes", bad, 0);
        chk("sweep_busy", busy_bad, 0);
        chk("sweep_end_busy", {31'd0, bus.busy}, 32'd0);
        chk("sweep_end_ready", {31'd0, bus.char_ready}, 32'd1);
        chk("sweep_end_cur", {17'd0, bus.cursor_addr}, 32'd0);
        @(posedge clk);
        #1;
        chk_wr("wr_K_after", 15'd0, 8'h4B, 15'd1);

        send(8'h0D);
        chk_nowr("cr_home", 15'd0);
        send(8'h08);
        chk_nowr("bs_at_home", 15'd0);

        send(8'h0C);
        bus.char_valid = 1'b0;
        repeat (501) @(posedge clk);
        #1;
        chk("sweep_500", {17'd0, bus.waddr}, 32'd500);
        chk("sweep_500_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.we !== 1'b0 || bus.busy !== 1'b0 ||
                bus.cursor_addr !== 15'd0)
                stray++;
        end
        chk("post_rst_quiet", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 Parameter COLS, default 128: characters per text row.
REQ-002 Parameter ROWS, default 80: text rows per screen; COLS*ROWS = 10240 cells.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 char_valid  input  1  producer offers char_in this cycle.
REQ-006 char_in  input  8  ASCII code from processor.
REQ-007 char_ready  output  1  block accepts char_in this cycle.
REQ-008 we  output  1  screen RAM write strobe, one cycle per cell write.
REQ-009 waddr  output  15  screen RAM write address, row*COLS+col.
REQ-010 wdata  output  8  screen RAM write data.
REQ-011 cursor_addr  output  15  current cursor cell address, for the VGA cursor overlay.
REQ-012 busy  output  1  clear sweep in progress.

Function
REQ-013 A character is accepted only on a rising edge with char_valid=1 and char_ready=1.
REQ-014 FSM states: IDLE, CLEAR; char_ready = 1 in IDLE, 0 in CLEAR; busy = 1 exactly in CLEAR.
REQ-015 IDLE accepts one character per cycle, back-to-back, with no bubbles.
REQ-016 Printable char (0x20-0x7E) accepted at cursor (r,c): next cycle we=1, waddr=r*COLS+c, wdata=char; cursor advances one cell.
REQ-017 Advance: c<COLS-1 -> c+1; c=COLS-1 -> c=0, row increments; row ROWS-1 wraps to row 0, giving address 10239 -> 0 with no scrolling.
REQ-018 0x0A (LF): c=0, row increments with the same wrap rule; no write.
REQ-019 0x0D (CR): c=0, row unchanged; no write.
REQ-020 0x08 (BS): c>0 -> c-1; c=0 and r>0 -> (r-1, COLS-1); next cycle we=1, wdata=0x00 at the new cursor address.
REQ-021 BS at (0,0): cursor unchanged, no write.
REQ-022 0x0C (FF): enter CLEAR; next cycle begins sweep writing wdata=0x00 to addresses 0..COLS*ROWS-1, one per cycle, ascending.
REQ-023 After the write to address COLS*ROWS-1, the cursor is set to (0,0) and the FSM returns to IDLE on the following edge.
REQ-024 A clear takes exactly COLS*ROWS write cycles.
REQ-025 All other codes (0x00-0x1F not listed above, 0x7F-0xFF) are consumed with no write and no cursor change.
REQ-026 we, waddr and wdata are registered outputs; we=0 in any cycle without a write.
REQ-027 waddr holds its last value while we=0.
REQ-028 cursor_addr is registered and reflects the cursor after each update, in the cycle the corresponding write appears.
REQ-029 char_valid is ignored during CLEAR; the producer holds char_in until char_ready.
REQ-030 Row and column counters are sized to the parameters; address arithmetic is zero-extended to 15 bits and never exceeds COLS*ROWS-1.

Reset
REQ-031 Asserting rst_n=0 immediately forces: state IDLE, cursor (0,0), we=0, waddr=0, wdata=0, cursor_addr=0, busy=0, char_ready=1.
REQ-032 Reset during CLEAR aborts the sweep and leaves already-written cells unrestored; no sweep runs after reset.
REQ-033 Reset does not alter RAM contents.

Structure
REQ-034 Shared package screen_pkg holds COLS, ROWS, SCREEN_CELLS=10240, ADDR_W=15, the ASCII constants LF, CR, BS, FF and NUL, and the FSM state enum.
REQ-035 Sub-module cursor_ctrl holds the row/column counters and the advance, newline, carriage-return, backspace and home operations, and outputs the linear address.
REQ-036 The top level holds the FSM, handshake, clear counter and output registers, and connects to the screen RAM write port.

Verification
REQ-037 Reset, then 'A','B' on consecutive cycles -> we pulses write 0x41@0 then 0x42@1; cursor_addr=2; char_ready stays 1.
REQ-038 Cursor at (0,127), send 'Z' -> write 0x5A@127; cursor_addr=128.
REQ-039 Cursor at (79,127), send 'Q' -> write 0x51@10239; cursor_addr=0.
REQ-040 Cursor at (3,5) (addr 389), send LF -> cursor_addr=512, no write; then BS -> cursor_addr=511, write 0x00@511.
REQ-041 Send FF -> busy=1 and char_ready=0 for 10240 cycles; writes 0x00 to 0..10239 in order; then cursor_addr=0 and char_ready=1; char_valid held high during the sweep is not accepted until the sweep ends.
REQ-042 Assert rst_n low at sweep address 500 -> all outputs at reset values asynchronously; after release, IDLE with cursor 0 and no further writes.
